led_fade_driver: RTL



---
 rtl/led_fade_pkg.sv | 22 ++
 rtl/led_fade_if.sv | 16 +
 rtl/led_fade_chan.sv | 61 ++++++
 rtl/led_fade_driver.sv | 63 ++++++
 4 files changed

// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED fade driver.
// LED_FADE_GAMMA_EN adds the gamma() duty mapping; without it duty is linear.
package led_fade_pkg;

  localparam int PWM_BITS = 8;

  typedef logic [PWM_BITS-1:0] level_t;

  localparam level_t PWM_MAX  = '1;
  localparam level_t PWM_LAST = level_t'(2**PWM_BITS - 2);

`ifdef LED_FADE_GAMMA_EN
  // Square-law map so the perceived fade is roughly linear; full-on is pinned.
  function automatic level_t gamma(input level_t lvl);
    logic [2*PWM_BITS-1:0] prod;
    prod = lvl * lvl;
    if (lvl == PWM_MAX) return PWM_MAX;
    return prod[2*PWM_BITS-1:PWM_BITS];
  endfunction
`endif

endpackage

// File: rtl/led_fade_if.sv
// Pattern-in / PWM-out bundle between the pattern generator, the fade driver and the pins.
interface led_fade_if
  import led_fade_pkg::*;
#(
  parameter int N_LED = 8
);

  logic [N_LED-1:0] led_in;
  level_t           global_level;
  logic [N_LED-1:0] led_out;
  logic             pwm_wrap;

  modport master (output led_in, global_level, input led_out, pwm_wrap);
  modport slave  (input led_in, global_level, output led_out, pwm_wrap);

endinterface

// File: rtl/led_fade_chan.sv
// One LED channel: instant-attack / linear-decay level, per-period duty latch, PWM compare.
// With LED_FADE_GAMMA_EN the duty latch stores gamma(level) instead of level.
module led_fade_chan
  import led_fade_pkg::*;
#(
  parameter int DECAY_STEP = 8
) (
  input  logic   clk50m,
  input  logic   rst_n,
  input  logic   lit,
  input  level_t lvl,
  input  logic   tick,
  input  logic   latch,
  input  level_t pwm_cnt,
  output logic   led_out
);

  localparam level_t STEP = level_t'(DECAY_STEP);

  level_t target;
  level_t level;
  level_t duty;
  level_t gap;
  level_t dec;
  level_t duty_next;

  assign target = lit ? lvl : '0;
  // gap is only consumed when level > target, so it never wraps in use.
  assign gap    = level - target;
  assign dec    = (gap > STEP) ? STEP : gap;

`ifdef LED_FADE_GAMMA_EN
  assign duty_next = gamma(level);
`else
  assign duty_next = level;
`endif

  // NOTE: every register here uses non-blocking assignment so all channels
  // and the shared counters update from the same pre-edge values.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      level   <= '0;
      duty    <= '0;
      led_out <= 1'b0;
    end else begin
      if (level < target) begin
        level <= target;
      end else if (tick && (level > target)) begin
        level <= level - dec;
      end

      // Duty only moves at the period boundary, so a period is never split.
      if (latch) begin
        duty <= duty_next;
      end

      led_out <= (pwm_cnt < duty);
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// Comet-tail LED driver: registers the pattern, runs the shared PWM and decay
// counters, and instantiates one led_fade_chan per LED (LED_FADE_GAMMA_EN selects gamma duty).
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int DECAY_DIV  = 195312,
  parameter int DECAY_STEP = 8
) (
  input  logic     clk50m,
  input  logic     rst_n,
  led_fade_if.slave bus
);

  localparam int TICK_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [N_LED-1:0]  led_in_q;
  logic [N_LED-1:0]  led_q;
  level_t            lvl_q;
  level_t            pwm_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              pwm_wrap_q;
  logic              period_end;
  logic              tick;

  assign period_end = (pwm_cnt == PWM_LAST);
  assign tick       = (tick_cnt == TICK_W'(DECAY_DIV - 1));

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      led_in_q   <= '0;
      lvl_q      <= '0;
      pwm_cnt    <= '0;
      tick_cnt   <= '0;
      pwm_wrap_q <= 1'b0;
    end else begin
      led_in_q   <= bus.led_in;
      lvl_q      <= bus.global_level;
      pwm_cnt    <= period_end ? '0 : pwm_cnt + 1'b1;
      tick_cnt   <= tick ? '0 : tick_cnt + 1'b1;
      pwm_wrap_q <= period_end;
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_chan
    led_fade_chan #(
      .DECAY_STEP (DECAY_STEP)
    ) u_chan (
      .clk50m  (clk50m),
      .rst_n   (rst_n),
      .lit     (led_in_q[i]),
      .lvl     (lvl_q),
      .tick    (tick),
      .latch   (period_end),
      .pwm_cnt (pwm_cnt),
      .led_out (led_q[i])
    );
  end

  assign bus.led_out  = led_q;
  assign bus.pwm_wrap = pwm_wrap_q;

endmodule
